shift_sequencer: RTL and testbench

//   Multi-cycle sequencer for R-type SLL/SRL; the single-cycle ALU does not implement shifts.

---
 rtl/shift_sequencer.sv | 110 +++++++++++
 tb/tb_shift_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle SLL/SRL sequencer beside the single-cycle ALU
//
// Shifts the latched operand one bit per clock and holds the PC via stall until
// the result is ready; the writeback mux takes result while done is high.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   start        in   shift request, sampled on rising clk
//   ALUOp        in   control-unit ALU op (3'b111 = R-type)
//   ALUFunction  in   funct field (6'h00 = SLL, 6'h02 = SRL)
//   shamt        in   shift amount
//   operand      in   value to shift
//   stall        out  hold PC/pipeline this cycle (combinational)
//   busy         out  registered, high while shifting
//   done         out  one-cycle pulse, result valid
//   result       out  shifted value, held until next completion or reset
module shift_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2:0]             ALUOp,
  input  logic [5:0]             ALUFunction,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  input  logic [DATA_WIDTH-1:0]  operand,
  output logic                   stall,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_WIDTH-1:0]  result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  shreg;
  logic [SHAMT_WIDTH-1:0] count;
  logic                   dir;      // 1 = SRL, 0 = SLL (funct bit 1)
  logic                   is_shift_op;
  logic                   accept;
  logic [DATA_WIDTH-1:0]  shifted;

  assign is_shift_op = (ALUOp == 3'b111) &&
                       ((ALUFunction == 6'h00) || (ALUFunction == 6'h02));

  // DONE accepts like IDLE so back-to-back shifts lose no cycle. Gating with
  // reset keeps stall low while reset is held even if start is asserted.
  assign accept = !reset && start && is_shift_op &&
                  ((state == IDLE) || (state == DONE));

  // Combinational so the accepting cycle already freezes the PC.
  assign stall = accept || (state == SHIFT);

  // Both directions are logical: zero fill, never sign fill.
  assign shifted = dir ? (shreg >> 1) : (shreg << 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      shreg  <= '0;
      count  <= '0;
      dir    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      busy <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (shamt != '0) begin
              state <= SHIFT;
              shreg <= operand;
              count <= shamt;
              dir   <= ALUFunction[1];
              busy  <= 1'b1;
            end else begin
              // Zero shift amount completes immediately with the operand.
              state  <= DONE;
              result <= operand;
              done   <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          shreg <= shifted;
          count <= count - SHAMT_WIDTH'(1);
          if (count == SHAMT_WIDTH'(1)) begin
            state  <= DONE;
            result <= shifted;
            done   <= 1'b1;
          end else begin
            busy <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - self-checking bench for shift_sequencer
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  alu_op;
  logic [5:0]  alu_fn;
  logic [4:0]  sh;
  logic [31:0] opnd;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  // Reference model: one transaction described by its accept cycle and length.
  bit          has_txn;
  int          c_a;
  int          s_a;
  logic [31:0] pend;
  logic [31:0] res_exp;
  int          cyc;
  int          stall_cnt, busy_cnt, done_cnt;

  shift_sequencer #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ALUOp       (alu_op),
    .ALUFunction (alu_fn),
    .shamt       (sh),
    .operand     (opnd),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .result      (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs just after posedge, check at negedge, update model.
  task automatic step(input bit st, input logic [2:0] op, input logic [5:0] fn,
                      input logic [4:0] s, input logic [31:0] d);
    bit in_shift, acc, dn;
    start  = st;
    alu_op = op;
    alu_fn = fn;
    sh     = s;
    opnd   = d;
    in_shift = has_txn && (cyc > c_a) && (cyc <= c_a + s_a);
    dn       = has_txn && (cyc == c_a + s_a + 1);
    if (dn) res_exp = pend;
    acc = st && (op == 3'b111) && ((fn == 6'h00) || (fn == 6'h02)) && !in_shift;
    @(negedge clk);
    check("stall",  {31'b0, stall}, {31'b0, in_shift || acc});
    check("busy",   {31'b0, busy},  {31'b0, in_shift});
    check("done",   {31'b0, done},  {31'b0, dn});
    check("result", result, res_exp);
    stall_cnt += int'(stall);
    busy_cnt  += int'(busy);
    done_cnt  += int'(done);
    if (acc) begin
      has_txn = 1'b1;
      c_a     = cyc;
      s_a     = int'(s);
      if (s == 5'd0)     pend = d;
      else if (fn[1])    pend = d >> s;
      else               pend = d << s;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'b000, 6'h00, 5'd0, 32'h0);
  endtask

  task automatic clr_cnt();
    stall_cnt = 0;
    busy_cnt  = 0;
    done_cnt  = 0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; alu_op = '0; alu_fn = '0; sh = '0; opnd = '0;
    has_txn = 1'b0; c_a = 0; s_a = 0; pend = '0; res_exp = '0; cyc = 0;
    clr_cnt();
    @(posedge clk);
    #1;
    check("rst_stall",  {31'b0, stall}, 32'd0);
    check("rst_busy",   {31'b0, busy},  32'd0);
    check("rst_done",   {31'b0, done},  32'd0);
    check("rst_result", result,         32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    // SLL by 4: five stall cycles, one done, 0x10.
    clr_cnt();
    step(1'b1, 3'b111, 6'h00, 5'd4, 32'h0000_0001);
    idle(7);
    check("t1_stall_cycles", stall_cnt, 32'd5);
    check("t1_done_pulses",  done_cnt,  32'd1);
    check("t1_result",       result,    32'h0000_0010);

    // SRL by 31: busy for 31 cycles.
    clr_cnt();
    step(1'b1, 3'b111, 6'h02, 5'd31, 32'h8000_0000);
    idle(34);
    check("t2_busy_cycles", busy_cnt, 32'd31);
    check("t2_done_pulses", done_cnt, 32'd1);
    check("t2_result",      result,   32'h0000_0001);

    // Zero shift: done next cycle, busy never set.
    clr_cnt();
    step(1'b1, 3'b111, 6'h00, 5'd0, 32'hDEAD_BEEF);
    check("t3_done_next", {31'b0, done}, 32'd1);
    idle(3);
    check("t3_busy_cycles", busy_cnt, 32'd0);
    check("t3_result",      result,   32'hDEAD_BEEF);

    // Non-shift requests are ignored.
    clr_cnt();
    step(1'b1, 3'b111, 6'h20, 5'd3, 32'h1234_5678);
    step(1'b1, 3'b000, 6'h00, 5'd3, 32'h1234_5678);
    step(1'b1, 3'b010, 6'h02, 5'd7, 32'hFFFF_FFFF);
    idle(3);
    check("t4_stall_cycles", stall_cnt, 32'd0);
    check("t4_done_pulses",  done_cnt,  32'd0);
    check("t4_result",       result,    32'hDEAD_BEEF);

    // start held through SHIFT is ignored, then accepted in the DONE cycle.
    clr_cnt();
    step(1'b1, 3'b111, 6'h02, 5'd6, 32'hF000_0000);
    for (int i = 0; i < 6; i++) step(1'b1, 3'b111, 6'h00, 5'd3, 32'h0000_0003);
    step(1'b1, 3'b111, 6'h00, 5'd3, 32'h0000_0003);
    check("t5_first_result", result, 32'h03C0_0000);
    idle(6);
    check("t5_done_pulses", done_cnt, 32'd2);
    check("t5_second_result", result, 32'h0000_0018);

    // Reset mid-SHIFT aborts without a done pulse.
    clr_cnt();
    step(1'b1, 3'b111, 6'h00, 5'd10, 32'h0000_0005);
    idle(2);
    check("t6_busy_before", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("t6_stall_async",  {31'b0, stall}, 32'd0);
    check("t6_busy_async",   {31'b0, busy},  32'd0);
    check("t6_result_async", result,         32'd0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    has_txn = 1'b0;
    res_exp = '0;
    clr_cnt();
    idle(12);
    check("t6_no_done", done_cnt, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [2:0]  op;
      logic [5:0]  fn;
      logic [4:0]  s;
      logic [31:0] d;
      bit          st;
      st = ($urandom_range(0, 2) != 0);
      op = ($urandom_range(0, 3) != 0) ? 3'b111 : 3'($urandom_range(0, 6));
      case ($urandom_range(0, 4))
        0, 1:    fn = 6'h00;
        2, 3:    fn = 6'h02;
        default: fn = 6'($urandom);
      endcase
      s = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      d = $urandom;
      step(st, op, fn, s, d);
    end
    idle(35);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
